// File: rtl/asymmetric_fifo_ctrl.sv
// Wide-in / narrow-out FIFO sequencer driving an asymmetric distributed RAM.
// Optional ASYM_FIFO_LEVEL_EN adds a registered unread sub-word count on `level`.
module asymmetric_fifo_ctrl #(
  parameter int WIDTH_IN     = 64,
  parameter int WIDTH_OUT    = 8,
  parameter int DEPTH_IN     = 32,
  parameter int ADDR_A_WIDTH = $clog2(DEPTH_IN),
  parameter int ADDR_B_WIDTH = $clog2(DEPTH_IN * (WIDTH_IN / WIDTH_OUT))
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic [WIDTH_IN-1:0]     in_data,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [WIDTH_OUT-1:0]    out_data,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic                    ram_we,
  output logic [ADDR_A_WIDTH-1:0] ram_addr_a,
  output logic [WIDTH_IN-1:0]     ram_in,
  output logic [ADDR_B_WIDTH-1:0] ram_addr_b,
  input  logic [WIDTH_OUT-1:0]    ram_out
`ifdef ASYM_FIFO_LEVEL_EN
  ,
  output logic [ADDR_B_WIDTH+1:0] level
`endif
);

  localparam int RATIO = WIDTH_IN / WIDTH_OUT;
  localparam int SUB_W = $clog2(RATIO);
  localparam logic [ADDR_A_WIDTH:0] DEPTH_W = (ADDR_A_WIDTH+1)'(DEPTH_IN);
  localparam logic [ADDR_A_WIDTH:0] WR_ONE  = (ADDR_A_WIDTH+1)'(1);
  localparam logic [ADDR_B_WIDTH:0] RD_ONE  = (ADDR_B_WIDTH+1)'(1);

  logic [ADDR_A_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_B_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_A_WIDTH:0] rd_word;
  logic [ADDR_A_WIDTH:0] words_used;
  logic                  sub_last;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;

  generate
    if (SUB_W == 0) begin : g_ratio1
      assign rd_word  = rd_ptr_q;
      assign sub_last = 1'b1;
      assign empty    = (rd_ptr_q == wr_ptr_q);
    end else begin : g_ratio_n
      assign rd_word  = rd_ptr_q[ADDR_B_WIDTH:SUB_W];
      assign sub_last = &rd_ptr_q[SUB_W-1:0];
      assign empty    = (rd_ptr_q == {wr_ptr_q, {SUB_W{1'b0}}});
    end
  endgenerate

  // A partially read word still counts as used until its last sub-word leaves.
  assign words_used = wr_ptr_q - rd_word;
  assign full       = (words_used == DEPTH_W);

  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign out_last  = out_valid & sub_last;
  assign out_data  = ram_out;

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  // Gate with rst so the RAM never sees a write while the pointers are held cleared.
  assign ram_we     = push & ~rst;
  assign ram_addr_a = wr_ptr_q[ADDR_A_WIDTH-1:0];
  assign ram_in     = in_data;
  assign ram_addr_b = rd_ptr_q[ADDR_B_WIDTH-1:0];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + WR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + RD_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

`ifdef ASYM_FIFO_LEVEL_EN
  localparam logic [ADDR_B_WIDTH+1:0] LVL_RATIO = (ADDR_B_WIDTH+2)'(RATIO);
  localparam logic [ADDR_B_WIDTH+1:0] LVL_ONE   = (ADDR_B_WIDTH+2)'(1);

  logic [ADDR_B_WIDTH+1:0] level_q, level_d;

  // A push adds a whole word of sub-words, a pop removes one.
  always_comb begin
    level_d = level_q;
    if (flush) begin
      level_d = '0;
    end else begin
      if (push) level_d = level_d + LVL_RATIO;
      if (pop)  level_d = level_d - LVL_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_q <= '0;
    else     level_q <= level_d;
  end

  assign level = level_q;
`endif

endmodule

// File: tb/tb_asymmetric_fifo_ctrl.sv
// Scoreboard bench for asymmetric_fifo_ctrl with a behavioural RAM and sub-word queue model.
module tb_asymmetric_fifo_ctrl;
  localparam int WIDTH_IN     = 64;
  localparam int WIDTH_OUT    = 8;
  localparam int DEPTH_IN     = 32;
  localparam int RATIO        = WIDTH_IN / WIDTH_OUT;
  localparam int ADDR_A_WIDTH = $clog2(DEPTH_IN);
  localparam int ADDR_B_WIDTH = $clog2(DEPTH_IN * RATIO);

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    flush = 1'b0;
  logic                    in_valid = 1'b0;
  logic [WIDTH_IN-1:0]     in_data = '0;
  logic                    out_ready = 1'b0;
  logic                    in_ready;
  logic                    out_valid;
  logic [WIDTH_OUT-1:0]    out_data;
  logic                    out_last;
  logic                    ram_we;
  logic [ADDR_A_WIDTH-1:0] ram_addr_a;
  logic [WIDTH_IN-1:0]     ram_in;
  logic [ADDR_B_WIDTH-1:0] ram_addr_b;
  logic [WIDTH_OUT-1:0]    ram_out;
`ifdef ASYM_FIFO_LEVEL_EN
  logic [ADDR_B_WIDTH+1:0] level;
`endif

  asymmetric_fifo_ctrl #(
    .WIDTH_IN (WIDTH_IN),
    .WIDTH_OUT(WIDTH_OUT),
    .DEPTH_IN (DEPTH_IN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .ram_we    (ram_we),
    .ram_addr_a(ram_addr_a),
    .ram_in    (ram_in),
    .ram_addr_b(ram_addr_b),
    .ram_out   (ram_out)
`ifdef ASYM_FIFO_LEVEL_EN
    ,
    .level     (level)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural asymmetric RAM: wide synchronous write, narrow combinational read.
  logic [WIDTH_IN-1:0] mem [DEPTH_IN];
  logic [WIDTH_IN-1:0] ram_word;
  always @(posedge clk) if (ram_we) mem[ram_addr_a] <= ram_in;
  always_comb begin
    ram_word = mem[int'(ram_addr_b) / RATIO];
    ram_out  = ram_word[(int'(ram_addr_b) % RATIO) * WIDTH_OUT +: WIDTH_OUT];
  end

  typedef struct packed {
    logic [WIDTH_OUT-1:0] data;
    logic                 last;
  } sub_t;

  sub_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_acc   = 0;
  int   n_pop   = 0;
  int   n_last  = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stimulus side: an accepted wide word becomes RATIO expected sub-words, LSB first.
  logic                acc_pend = 1'b0;
  logic [WIDTH_IN-1:0] acc_data = '0;
  sub_t                acc_s;
  always @(negedge clk) begin
    acc_pend = !rst && in_valid && in_ready && !flush;
    acc_data = in_data;
  end
  always @(posedge clk) begin
    if (acc_pend && !rst) begin
      for (int k = 0; k < RATIO; k++) begin
        acc_s.data = acc_data[k*WIDTH_OUT +: WIDTH_OUT];
        acc_s.last = (k == RATIO - 1);
        exp_q.push_back(acc_s);
      end
      n_acc++;
    end
    acc_pend = 1'b0;
  end

  // Monitor: compares DUT outputs against the queue model every cycle.
  int   mon_words;
  sub_t mon_s;
  always @(negedge clk) begin
    if (!rst) begin
      mon_words = (exp_q.size() + RATIO - 1) / RATIO;
      check("out_valid", out_valid, exp_q.size() != 0);
      check("in_ready", in_ready, mon_words < DEPTH_IN);
      check("ram_we", ram_we, in_valid && (mon_words < DEPTH_IN) && !flush);
      check("out_last", out_last, (exp_q.size() != 0) && exp_q[0].last);
`ifdef ASYM_FIFO_LEVEL_EN
      check("level", level, exp_q.size());
`endif
      if (flush) begin
        exp_q.delete();
      end else if (out_valid && out_ready && exp_q.size() != 0) begin
        mon_s = exp_q.pop_front();
        check("out_data", out_data, mon_s.data);
        n_pop++;
        if (out_last) n_last++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 600 && exp_q.size() != 0; i++) cyc();
    check("drain_timeout", exp_q.size(), 0);
    out_ready = 1'b0;
    cyc();
  endtask

  int start;
  int target;
  int pops0;
  int lasts0;

  initial begin
    // Reset values, with in_valid high to show the write is suppressed.
    in_valid = 1'b1;
    #3;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr_a", ram_addr_a, 0);
    check("rst_ram_addr_b", ram_addr_b, 0);
    in_valid = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();

    // Single word, continuous pop: bytes 00..07 in order, last only on 07.
    pops0     = n_pop;
    lasts0    = n_last;
    in_valid  = 1'b1;
    in_data   = 64'h0706050403020100;
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    repeat (12) cyc();
    check("single_pops", n_pop - pops0, RATIO);
    check("single_lasts", n_last - lasts0, 1);
    check("single_empty", out_valid, 0);

    // Fill to capacity, then free exactly one word.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    start     = n_acc;
    for (int i = 0; i < 200 && (n_acc - start) < DEPTH_IN; i++) begin
      in_data = {$urandom, $urandom};
      cyc();
    end
    check("fill_count", n_acc - start, DEPTH_IN);
    check("full_in_ready", in_ready, 0);
    repeat (3) begin
      in_data = {$urandom, $urandom};
      cyc();
    end
    check("push_while_full", n_acc - start, DEPTH_IN);
    out_ready = 1'b1;
    repeat (RATIO - 1) cyc();
    check("partial_word_in_ready", in_ready, 0);
    cyc();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("freed_word_in_ready", in_ready, 1);
    drain();

    // Random push/pop over 300 words, crossing the pointer wrap several times.
    target = n_acc + 300;
    for (int i = 0; i < 20000 && !(n_acc >= target && exp_q.size() == 0); i++) begin
      in_valid  = (n_acc < target) && ($urandom % 4 != 0);
      in_data   = {$urandom, $urandom};
      out_ready = ($urandom % 3 != 0);
      cyc();
    end
    check("random_words", n_acc, target);
    check("random_drained", exp_q.size(), 0);
    drain();

    // Flush after a partial read; the same-cycle push and pop are dropped.
    in_valid = 1'b1;
    repeat (3) begin
      in_data = {$urandom, $urandom};
      cyc();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) cyc();
    in_valid = 1'b1;
    in_data  = {$urandom, $urandom};
    flush    = 1'b1;
    cyc();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    check("flush_addr_b", ram_addr_b, 0);
`ifdef ASYM_FIFO_LEVEL_EN
    check("flush_level", level, 0);
`endif
    repeat (3) cyc();
    out_ready = 1'b0;

    // Asynchronous reset in the middle of a pop.
    in_valid = 1'b1;
    repeat (2) begin
      in_data = {$urandom, $urandom};
      cyc();
    end
    out_ready = 1'b1;
    in_data   = {$urandom, $urandom};
    cyc();
    #1;
    rst = 1'b1;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_ram_we", ram_we, 0);
    check("async_ram_addr_b", ram_addr_b, 0);
    check("async_ram_addr_a", ram_addr_a, 0);
    check("async_in_ready", in_ready, 1);
    exp_q.delete();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    check("post_rst_out_valid", out_valid, 0);

    // Still operational after reset.
    in_valid = 1'b1;
    in_data  = {$urandom, $urandom};
    cyc();
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
